// File: rtl/proto_pkg.sv
// Shared definitions for the execute sequencer: opcodes, FSM encoding, instruction fields.
package proto_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_NOT = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_SHR = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  localparam int OP_MSB   = 15;
  localparam int OP_LSB   = 13;
  localparam int RD_MSB   = 12;
  localparam int RD_LSB   = 10;
  localparam int RSA_MSB  = 9;
  localparam int RSA_LSB  = 7;
  localparam int NOWB_BIT = 6;
  localparam int BIMM_BIT = 5;
  localparam int IMM_MSB  = 4;
  localparam int IMM_LSB  = 0;
  localparam int RSB_MSB  = 4;
  localparam int RSB_LSB  = 2;

  // Only arithmetic ops produce a meaningful carry; logic/shift ops leave C untouched.
  function automatic logic updates_carry(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/reg_file.sv
// 8-entry register file: two operand read ports and a debug read port (all combinational),
// one synchronous write port; synchronous reset clears every entry.
module reg_file #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int AW     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [AW-1:0]     raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic [AW-1:0]     raddr_dbg,
  output logic [DATA_W-1:0] rdata_dbg
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a   = mem[raddr_a];
  assign rdata_b   = mem[raddr_b];
  assign rdata_dbg = mem[raddr_dbg];

endmodule

// File: rtl/exec_sequencer.sv
// Four-cycle execute controller feeding an external combinational ALU; one instruction per 4 cycles.
// in_ready is high only in IDLE, so an offered instruction waits there until the previous one retires.
module exec_sequencer
  import proto_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       instr,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_op,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zero,
  input  logic              alu_carry,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              flag_z,
  output logic              flag_c,
  input  logic [2:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  state_t            state;
  logic [15:0]       ir;
  logic [DATA_W-1:0] res_q;
  logic              zero_q;
  logic              carry_q;
  logic [DATA_W-1:0] rdata_a;
  logic [DATA_W-1:0] rdata_b;
  logic [DATA_W-1:0] imm_ext;
  logic              we;

  assign imm_ext = {{(DATA_W-5){1'b0}}, ir[IMM_MSB:IMM_LSB]};
  // Write lands on the edge that ends WB, after operands were already sampled in READ.
  assign we      = (state == ST_WB) && !ir[NOWB_BIT];

  reg_file #(
    .DATA_W(DATA_W),
    .DEPTH (8),
    .AW    (3)
  ) u_reg_file (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .waddr    (ir[RD_MSB:RD_LSB]),
    .wdata    (res_q),
    .raddr_a  (ir[RSA_MSB:RSA_LSB]),
    .rdata_a  (rdata_a),
    .raddr_b  (ir[RSB_MSB:RSB_LSB]),
    .rdata_b  (rdata_b),
    .raddr_dbg(dbg_addr),
    .rdata_dbg(dbg_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      in_ready <= 1'b1;
      ir       <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= OP_ADD;
      res_q    <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      flag_z   <= 1'b0;
      flag_c   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (in_valid) begin
            ir       <= instr;
            in_ready <= 1'b0;
            state    <= ST_READ;
          end
        end
        ST_READ: begin
          alu_a  <= rdata_a;
          alu_b  <= ir[BIMM_BIT] ? imm_ext : rdata_b;
          alu_op <= ir[OP_MSB:OP_LSB];
          state  <= ST_EXEC;
        end
        ST_EXEC: begin
          res_q   <= alu_out;
          zero_q  <= alu_zero;
          carry_q <= alu_carry;
          done    <= 1'b1;
          state   <= ST_WB;
        end
        ST_WB: begin
          result <= res_q;
          flag_z <= zero_q;
          if (updates_carry(ir[OP_MSB:OP_LSB])) flag_c <= carry_q;
          in_ready <= 1'b1;
          state    <= ST_IDLE;
        end
        default: begin
          in_ready <= 1'b1;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer with a behavioural 8-bit ALU attached to its operand ports.
module tb_exec_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] instr;
  logic [7:0]  alu_a, alu_b, alu_out;
  logic [2:0]  alu_op;
  logic        alu_zero, alu_carry;
  logic        done;
  logic [7:0]  result;
  logic        flag_z, flag_c;
  logic [2:0]  dbg_addr;
  logic [7:0]  dbg_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  exec_sequencer #(.DATA_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .instr    (instr),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_op   (alu_op),
    .alu_out  (alu_out),
    .alu_zero (alu_zero),
    .alu_carry(alu_carry),
    .done     (done),
    .result   (result),
    .flag_z   (flag_z),
    .flag_c   (flag_c),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  // Reference ALU: SUB carry is the borrow (a < b); shifts carry out the shifted-off bit.
  logic [8:0] sum;
  always_comb begin
    sum       = '0;
    alu_out   = '0;
    alu_carry = 1'b0;
    case (alu_op)
      3'd0: begin sum = {1'b0, alu_a} + {1'b0, alu_b}; alu_out = sum[7:0]; alu_carry = sum[8]; end
      3'd1: begin alu_out = alu_a - alu_b; alu_carry = (alu_a < alu_b); end
      3'd2: alu_out = alu_a & alu_b;
      3'd3: alu_out = alu_a | alu_b;
      3'd4: alu_out = alu_a ^ alu_b;
      3'd5: alu_out = ~alu_a;
      3'd6: begin alu_out = {alu_a[6:0], 1'b0}; alu_carry = alu_a[7]; end
      default: begin alu_out = {1'b0, alu_a[7:1]}; alu_carry = alu_a[0]; end
    endcase
    alu_zero = (alu_out == 8'h00);
  end

  function automatic logic [15:0] mk_i(input logic [2:0] op, input logic [2:0] rd,
                                       input logic [2:0] rsa, input logic nowb, input logic [4:0] imm);
    return {op, rd, rsa, nowb, 1'b1, imm};
  endfunction

  function automatic logic [15:0] mk_r(input logic [2:0] op, input logic [2:0] rd,
                                       input logic [2:0] rsa, input logic nowb, input logic [2:0] rsb);
    return {op, rd, rsa, nowb, 1'b0, rsb, 2'b00};
  endfunction

  task automatic rd_reg(input logic [2:0] a, output logic [7:0] v);
    dbg_addr = a;
    #1;
    v = dbg_data;
  endtask

  // Starts at a negedge with the DUT idle; returns cycles from handshake to done (-1 on timeout)
  // and leaves the bench at the negedge of the cycle after WB.
  task automatic issue(input logic [15:0] ins, output int lat);
    in_valid = 1'b1;
    instr    = ins;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    instr    = '0;
    lat      = -1;
    for (int k = 1; k <= 8; k++) begin
      if (done === 1'b1) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    logic [7:0] v;
    rst = 1'b1; in_valid = 1'b0; instr = '0; dbg_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (flag_z !== 1'b0) begin failures++; $display("FAIL reset_flag_z got=%b exp=0", flag_z); end
    checks++; if (flag_c !== 1'b0) begin failures++; $display("FAIL reset_flag_c got=%b exp=0", flag_c); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (result !== 8'h00) begin failures++; $display("FAIL reset_result got=%h exp=00", result); end
    checks++; if ({alu_a, alu_b, alu_op} !== 19'h0) begin failures++; $display("FAIL reset_alu got=%h/%h/%h exp=0/0/0", alu_a, alu_b, alu_op); end
    for (int i = 0; i < 8; i++) begin
      rd_reg(i[2:0], v);
      checks++; if (v !== 8'h00) begin failures++; $display("FAIL reset_reg r%0d got=%h exp=00", i, v); end
    end
  endtask

  task automatic test_add_imm;
    int lat; logic [7:0] v;
    issue(mk_i(3'd0, 3'd1, 3'd0, 1'b0, 5'd20), lat);
    checks++; if (lat != 3) begin failures++; $display("FAIL add_latency got=%0d exp=3", lat); end
    rd_reg(3'd1, v);
    checks++; if (v !== 8'h14) begin failures++; $display("FAIL add_r1 got=%h exp=14", v); end
    checks++; if ({flag_z, flag_c} !== 2'b00) begin failures++; $display("FAIL add_flags zc got=%b%b exp=00", flag_z, flag_c); end
    checks++; if (result !== 8'h14) begin failures++; $display("FAIL add_result got=%h exp=14", result); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL add_ready_after got=%b exp=1", in_ready); end
  endtask

  task automatic test_arith;
    int lat; logic [7:0] v;
    issue(mk_i(3'd0, 3'd2, 3'd1, 1'b0, 5'd25), lat);
    rd_reg(3'd2, v);
    checks++; if (v !== 8'h2D) begin failures++; $display("FAIL add_r2 got=%h exp=2d", v); end
    issue(mk_i(3'd1, 3'd3, 3'd0, 1'b0, 5'd1), lat);
    rd_reg(3'd3, v);
    checks++; if (v !== 8'hFF) begin failures++; $display("FAIL sub_r3 got=%h exp=ff", v); end
    checks++; if ({flag_z, flag_c} !== 2'b01) begin failures++; $display("FAIL sub_flags zc got=%b%b exp=01", flag_z, flag_c); end
    issue(mk_i(3'd0, 3'd4, 3'd3, 1'b0, 5'd1), lat);
    rd_reg(3'd4, v);
    checks++; if (v !== 8'h00) begin failures++; $display("FAIL wrap_r4 got=%h exp=00", v); end
    checks++; if ({flag_z, flag_c} !== 2'b11) begin failures++; $display("FAIL wrap_flags zc got=%b%b exp=11", flag_z, flag_c); end
  endtask

  task automatic test_logic_hold_c;
    int lat; logic [7:0] v;
    issue(mk_r(3'd4, 3'd5, 3'd3, 1'b0, 3'd3), lat);
    rd_reg(3'd5, v);
    checks++; if (v !== 8'h00) begin failures++; $display("FAIL xor_r5 got=%h exp=00", v); end
    checks++; if ({flag_z, flag_c} !== 2'b11) begin failures++; $display("FAIL xor_flags zc got=%b%b exp=11", flag_z, flag_c); end
    issue(mk_r(3'd6, 3'd6, 3'd1, 1'b0, 3'd0), lat);
    rd_reg(3'd6, v);
    checks++; if (v !== 8'h28) begin failures++; $display("FAIL shl_r6 got=%h exp=28", v); end
    checks++; if ({flag_z, flag_c} !== 2'b01) begin failures++; $display("FAIL shl_flags zc got=%b%b exp=01", flag_z, flag_c); end
    checks++; if ({alu_op, alu_a} !== {3'd6, 8'h14}) begin failures++; $display("FAIL shl_alu_ports op/a got=%0d/%h exp=6/14", alu_op, alu_a); end
  endtask

  task automatic test_no_wb;
    int lat; logic [7:0] v;
    issue(mk_i(3'd0, 3'd7, 3'd1, 1'b1, 5'd3), lat);
    rd_reg(3'd7, v);
    checks++; if (v !== 8'h00) begin failures++; $display("FAIL nowb_add_r7 got=%h exp=00", v); end
    checks++; if (result !== 8'h17) begin failures++; $display("FAIL nowb_add_result got=%h exp=17", result); end
    checks++; if (lat != 3) begin failures++; $display("FAIL nowb_done_latency got=%0d exp=3", lat); end
    issue(mk_r(3'd1, 3'd7, 3'd1, 1'b1, 3'd1), lat);
    rd_reg(3'd7, v);
    checks++; if (v !== 8'h00) begin failures++; $display("FAIL nowb_sub_r7 got=%h exp=00", v); end
    checks++; if (result !== 8'h00) begin failures++; $display("FAIL nowb_sub_result got=%h exp=00", result); end
    checks++; if ({flag_z, flag_c} !== 2'b10) begin failures++; $display("FAIL nowb_sub_flags zc got=%b%b exp=10", flag_z, flag_c); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] prog [3];
    int idx = 0, ndone = 0, cyc = 0, last = -100;
    logic hs;
    logic [7:0] v;
    prog[0] = mk_i(3'd0, 3'd1, 3'd1, 1'b0, 5'd1);  // r1 = 0x14 + 1
    prog[1] = mk_i(3'd0, 3'd2, 3'd1, 1'b0, 5'd2);  // r2 = 0x15 + 2
    prog[2] = mk_i(3'd3, 3'd3, 3'd2, 1'b0, 5'd8);  // r3 = 0x17 | 0x08
    in_valid = 1'b1;
    instr    = prog[0];
    while (cyc < 40 && !(idx == 3 && cyc > last + 4)) begin
      hs = 1'b0;
      if (done === 1'b1) ndone++;
      if (idx > 0 && cyc > last && cyc <= last + 3) begin
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_ready_low cyc=%0d got=%b exp=0", cyc, in_ready); end
      end
      if (in_ready === 1'b1 && in_valid && idx < 3) begin
        if (idx > 0) begin
          checks++; if (cyc - last != 4) begin failures++; $display("FAIL b2b_gap got=%0d exp=4", cyc - last); end
        end
        last = cyc;
        idx++;
        hs = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (hs) begin
        if (idx < 3) instr = prog[idx];
        else begin in_valid = 1'b0; instr = '0; end
      end
    end
    in_valid = 1'b0;
    checks++; if (idx != 3) begin failures++; $display("FAIL b2b_accepted got=%0d exp=3", idx); end
    checks++; if (ndone != 3) begin failures++; $display("FAIL b2b_done_count got=%0d exp=3", ndone); end
    rd_reg(3'd1, v);
    checks++; if (v !== 8'h15) begin failures++; $display("FAIL b2b_r1 got=%h exp=15", v); end
    rd_reg(3'd2, v);
    checks++; if (v !== 8'h17) begin failures++; $display("FAIL b2b_r2 got=%h exp=17", v); end
    rd_reg(3'd3, v);
    checks++; if (v !== 8'h1F) begin failures++; $display("FAIL b2b_r3 got=%h exp=1f", v); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] v;
    in_valid = 1'b1;
    instr    = mk_i(3'd0, 3'd1, 3'd1, 1'b0, 5'd5);
    @(posedge clk);
    @(negedge clk);                      // READ
    in_valid = 1'b0;
    instr    = '0;
    @(negedge clk);                      // EXEC
    checks++; if ({alu_a, alu_b, alu_op} !== {8'h15, 8'h05, 3'd0}) begin failures++; $display("FAIL mid_alu_ports got=%h/%h/%0d exp=15/05/0", alu_a, alu_b, alu_op); end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL mid_done got=%b exp=0", done); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_in_ready got=%b exp=1", in_ready); end
    checks++; if ({flag_z, flag_c} !== 2'b00) begin failures++; $display("FAIL mid_flags zc got=%b%b exp=00", flag_z, flag_c); end
    checks++; if ({alu_a, alu_b, alu_op} !== 19'h0) begin failures++; $display("FAIL mid_alu_reset got=%h/%h/%h exp=0/0/0", alu_a, alu_b, alu_op); end
    checks++; if (result !== 8'h00) begin failures++; $display("FAIL mid_result got=%h exp=00", result); end
    rd_reg(3'd1, v);
    checks++; if (v !== 8'h00) begin failures++; $display("FAIL mid_r1 got=%h exp=00", v); end
    rd_reg(3'd3, v);
    checks++; if (v !== 8'h00) begin failures++; $display("FAIL mid_r3 got=%h exp=00", v); end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL mid_no_done cyc=%0d got=%b exp=0", i, done); end
    end
    rd_reg(3'd1, v);
    checks++; if (v !== 8'h00) begin failures++; $display("FAIL mid_r1_after got=%h exp=00", v); end
  endtask

  initial begin
    test_reset();
    test_add_imm();
    test_arith();
    test_logic_hold_c();
    test_no_wb();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
